vec_vrf_banked: RTL and testbench
=================================

Name: vec_vrf_banked

Overview:
- Banked, parametrised vector register file for the RVV datapath; successor of the flat 32x512 VRF.
- Registers are interleaved across NBANK single-read banks. Read ports use a valid/ready handshake with per-bank round-robin arbitration.
- All write ports forward byte-wise into same-cycle reads.
- After reset, a built-in sequencer zero-initialises storage, so the array itself needs no reset.

Parameters:
NREG, 32, number of vector registers (power of 2, >= NBANK)
VLEN, 512, register width in bits (multiple of 8)
NBANK, 4, number of banks (power of 2); bank = addr[$clog2(NBANK)-1:0]
WPORT, 2, write ports
RPORT, 4, read ports
(derived) AW = $clog2(NREG), NB = VLEN/8

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_valid  in  WPORT  write request per port
wr_ready  out  WPORT  write accepted; all bits 1 in RUN, all bits 0 in INIT
wr_addr  in  WPORT*AW  write register index
wr_be  in  WPORT*NB  byte enables
wr_data  in  WPORT*VLEN  write data
rd_valid  in  RPORT  read request; must hold addr stable until accepted
rd_ready  out  RPORT  read accepted this cycle
rd_addr  in  RPORT*AW  read register index
rd_rvalid  out  RPORT  read data valid, one cycle after accept
rd_rdata  out  RPORT*VLEN  read data; holds the last value until the next accept
init_done  out  1  high once initialisation is complete

Behaviour:
- Reset (async):
  - FSM enters INIT with init_cnt=0.
  - rd_rvalid=0, rd_rdata=0, init_done=0, rd_ready=0, wr_ready=0.
  - Every bank round-robin pointer resets to 0.
- FSM:
  - INIT: writes zero to reg[init_cnt] each cycle and increments init_cnt. After reg[NREG-1] is written, the next state is RUN. INIT takes exactly NREG cycles.
  - RUN: init_done=1. RUN is terminal until reset.
  - rst_n asserted mid-INIT or mid-RUN restarts INIT from 0.
- Writes (RUN only):
  - A write is accepted when wr_valid & wr_ready. It updates the bytes with be=1 at the clock edge.
  - Two or more ports hitting the same register and byte in one cycle: the highest port index wins.
  - Writes never stall. There is no bank restriction on writes.
- Read arbitration (RUN only, combinational):
  - Each bank grants at most one requesting port per cycle.
  - The grant goes to the first requester at or after that bank's rr pointer, searching in increasing index with wrap.
  - On a grant, the pointer moves to granted port + 1 (mod RPORT). With no request, the pointer holds.
  - rd_ready[i] = grant[i]. Ports requesting different banks are all granted in the same cycle.
  - A port whose rd_valid drops without acceptance is simply not considered; no state is kept.
- Read data:
  - On accept, rd_rdata[i] is registered at the next edge and rd_rvalid[i]=1 for exactly one cycle.
  - Latency is 1 cycle from accept.
- Forwarding:
  - A read accepted in the same cycle as an accepted write to the same register returns the new bytes where be=1 and the old bytes elsewhere.
  - With multiple writers, the highest write port wins per byte.
  - The result is identical to write-before-read.
- Widths: addresses ≥ NREG are impossible by construction (AW=log2). Pointers are $clog2(RPORT) bits, and wrap from RPORT-1 to 0.

Optional Feature:
VRF_PARITY_EN
- Defined:
  - Each stored byte carries an even-parity bit, computed on write (including INIT zeros).
  - Extra output rd_perr (RPORT) is registered alongside rd_rdata and pulses with rd_rvalid if any byte read from the array fails parity. Forwarded bytes never flag.
  - Extra input par_inj (WPORT) flips the stored parity bits of that port's written bytes, for test.
  - rd_perr resets to 0.
- Undefined: no parity storage, no rd_perr or par_inj ports; behaviour is otherwise identical.

Test Plan:
- Reset then idle:
  - rd_ready=0 and init_done=0 for 32 cycles; init_done=1 in cycle 33.
  - A read of every register returns 0.
- Write v5 = 0xA5 repeated with all be, then read v5 next cycle on port 0 -> rd_rvalid[0]=1 one cycle after accept, rdata = all 0xA5.
- Ports 0..3 all read v1, v5, v9, v13 (all bank 1) with pointer=0:
  - Granted in order 0,1,2,3 over 4 cycles, one per cycle.
  - Pointer ends at 0.
  - Reading v0, v1, v2, v3 instead grants all four in one cycle.
- Same cycle:
  - Wport0 writes v7 with data 0x11.., be=all.
  - Wport1 writes v7 with data 0x22.., be = lower half.
  - Rport2 reads v7.
  - Required: rdata lower half = 0x22, upper half = 0x11, and the array matches afterwards.
- Assert rst_n low mid-RUN after writing v3=0xFF.. -> outputs clear, INIT reruns for 32 cycles, and v3 reads 0.
- With VRF_PARITY_EN: write v2 with par_inj[0]=1, then read v2 -> rd_perr[0]=1 with rd_rvalid.

Source files
------------

// File: rtl/vec_vrf_banked_if.sv
// Bus bundle for vec_vrf_banked: write ports, read request ports and read responses.
// With VRF_PARITY_EN defined it also carries par_inj (write side) and rd_perr (read side).
interface vec_vrf_banked_if #(
    parameter int NREG  = 32,
    parameter int VLEN  = 512,
    parameter int WPORT = 2,
    parameter int RPORT = 4
);
    localparam int AW = $clog2(NREG);
    localparam int NB = VLEN / 8;

    logic [WPORT-1:0]      wr_valid;
    logic [WPORT-1:0]      wr_ready;
    logic [WPORT*AW-1:0]   wr_addr;
    logic [WPORT*NB-1:0]   wr_be;
    logic [WPORT*VLEN-1:0] wr_data;
    logic [RPORT-1:0]      rd_valid;
    logic [RPORT-1:0]      rd_ready;
    logic [RPORT*AW-1:0]   rd_addr;
    logic [RPORT-1:0]      rd_rvalid;
    logic [RPORT*VLEN-1:0] rd_rdata;
`ifdef VRF_PARITY_EN
    logic [WPORT-1:0]      par_inj;
    logic [RPORT-1:0]      rd_perr;

    modport master (
        output wr_valid, wr_addr, wr_be, wr_data, rd_valid, rd_addr, par_inj,
        input  wr_ready, rd_ready, rd_rvalid, rd_rdata, rd_perr
    );
    modport slave (
        input  wr_valid, wr_addr, wr_be, wr_data, rd_valid, rd_addr, par_inj,
        output wr_ready, rd_ready, rd_rvalid, rd_rdata, rd_perr
    );
`else
    modport master (
        output wr_valid, wr_addr, wr_be, wr_data, rd_valid, rd_addr,
        input  wr_ready, rd_ready, rd_rvalid, rd_rdata
    );
    modport slave (
        input  wr_valid, wr_addr, wr_be, wr_data, rd_valid, rd_addr,
        output wr_ready, rd_ready, rd_rvalid, rd_rdata
    );
`endif
endinterface

// File: rtl/vec_vrf_banked.sv
// Banked vector register file: per-bank round-robin read arbitration, byte-wise write-to-read
// forwarding and a zeroing sweep after reset. VRF_PARITY_EN adds per-byte even parity.
//
// state  | meaning
// S_INIT | zero reg[init_cnt_q] each cycle; no reads or writes accepted
// S_RUN  | normal operation; terminal until reset
module vec_vrf_banked #(
    parameter int NREG  = 32,
    parameter int VLEN  = 512,
    parameter int NBANK = 4,
    parameter int WPORT = 2,
    parameter int RPORT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            init_done,
    vec_vrf_banked_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam int NB = VLEN / 8;
    localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int PW = (RPORT > 1) ? $clog2(RPORT) : 1;

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e                state_q;
    logic [AW-1:0]         init_cnt_q;
    logic [7:0]            mem_q [NREG][NB];
    logic [PW-1:0]         ptr_q [NBANK];
    logic [PW-1:0]         ptr_d [NBANK];
    logic [RPORT-1:0]      grant;
    logic [RPORT-1:0]      rvalid_q;
    logic [RPORT*VLEN-1:0] rdata_q;
    logic [VLEN-1:0]       fwd [RPORT];
    logic [AW-1:0]         wa [WPORT];
    logic [AW-1:0]         ra [RPORT];
    logic [WPORT-1:0]      wacc;
    logic                  run;
`ifdef VRF_PARITY_EN
    logic                  par_q [NREG][NB];
    logic [RPORT-1:0]      perr_d;
    logic [RPORT-1:0]      perr_q;
`endif

    assign run           = (state_q == S_RUN);
    assign init_done     = run;
    assign wacc          = bus.wr_valid & {WPORT{run}};
    assign bus.wr_ready  = {WPORT{run}};
    assign bus.rd_ready  = grant;
    assign bus.rd_rvalid = rvalid_q;
    assign bus.rd_rdata  = rdata_q;
`ifdef VRF_PARITY_EN
    assign bus.rd_perr   = perr_q;
`endif

    always_comb begin
        for (int p = 0; p < WPORT; p++) wa[p] = bus.wr_addr[p*AW +: AW];
        for (int i = 0; i < RPORT; i++) ra[i] = bus.rd_addr[i*AW +: AW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
        end else if (state_q == S_INIT) begin
            init_cnt_q <= init_cnt_q + 1'b1;
            if (init_cnt_q == AW'(NREG - 1)) state_q <= S_RUN;
        end
    end

    // No reset on the array; the INIT sweep zeroes it. Later ports' updates land last, so the highest port wins.
    always_ff @(posedge clk) begin
        if (!run) begin
            for (int b = 0; b < NB; b++) begin
                mem_q[init_cnt_q][b] <= 8'h00;
`ifdef VRF_PARITY_EN
                par_q[init_cnt_q][b] <= 1'b0;
`endif
            end
        end else begin
            for (int p = 0; p < WPORT; p++) begin
                for (int b = 0; b < NB; b++) begin
                    if (wacc[p] && bus.wr_be[p*NB + b]) begin
                        mem_q[wa[p]][b] <= bus.wr_data[p*VLEN + b*8 +: 8];
`ifdef VRF_PARITY_EN
                        par_q[wa[p]][b] <= (^bus.wr_data[p*VLEN + b*8 +: 8]) ^ bus.par_inj[p];
`endif
                    end
                end
            end
        end
    end

    // Each bank grants the first requester at or after its pointer, wrapping.
    always_comb begin
        logic          hit;
        int            sum;
        logic [PW-1:0] idx;
        hit   = 1'b0;
        sum   = 0;
        idx   = '0;
        grant = '0;
        for (int k = 0; k < NBANK; k++) begin
            ptr_d[k] = ptr_q[k];
            hit      = 1'b0;
            for (int off = 0; off < RPORT; off++) begin
                sum = int'(ptr_q[k]) + off;
                if (sum >= RPORT) sum = sum - RPORT;
                idx = PW'(sum);
                if (!hit && run && bus.rd_valid[idx] &&
                    (NBANK == 1 || int'(ra[idx][BW-1:0]) == k)) begin
                    hit        = 1'b1;
                    grant[idx] = 1'b1;
                    ptr_d[k]   = (sum == RPORT - 1) ? '0 : idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NBANK; k++) ptr_q[k] <= '0;
        end else begin
            for (int k = 0; k < NBANK; k++) ptr_q[k] <= ptr_d[k];
        end
    end

    // Overlay same-cycle writes in port order so the result equals write-before-read.
    always_comb begin
`ifdef VRF_PARITY_EN
        logic [NB-1:0] fhit;
        fhit   = '0;
        perr_d = '0;
`endif
        for (int i = 0; i < RPORT; i++) begin
`ifdef VRF_PARITY_EN
            fhit = '0;
`endif
            for (int b = 0; b < NB; b++) fwd[i][b*8 +: 8] = mem_q[ra[i]][b];
            for (int p = 0; p < WPORT; p++) begin
                for (int b = 0; b < NB; b++) begin
                    if (wacc[p] && wa[p] == ra[i] && bus.wr_be[p*NB + b]) begin
                        fwd[i][b*8 +: 8] = bus.wr_data[p*VLEN + b*8 +: 8];
`ifdef VRF_PARITY_EN
                        fhit[b] = 1'b1;
`endif
                    end
                end
            end
`ifdef VRF_PARITY_EN
            for (int b = 0; b < NB; b++) begin
                if (!fhit[b] && ((^mem_q[ra[i]][b]) != par_q[ra[i]][b])) perr_d[i] = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
`ifdef VRF_PARITY_EN
            perr_q   <= '0;
`endif
        end else begin
            rvalid_q <= grant;
            for (int i = 0; i < RPORT; i++) begin
                if (grant[i]) rdata_q[i*VLEN +: VLEN] <= fwd[i];
            end
`ifdef VRF_PARITY_EN
            perr_q   <= grant & perr_d;
`endif
        end
    end
endmodule

// File: tb/tb_vec_vrf_banked.sv
// Self-checking bench for vec_vrf_banked: directed scenarios plus randomized traffic against
// a register-array model with per-bank closest-to-pointer arbitration.
module tb_vec_vrf_banked;
    localparam int NREG  = 32;
    localparam int VLEN  = 512;
    localparam int NBANK = 4;
    localparam int WPORT = 2;
    localparam int RPORT = 4;
    localparam int AW    = $clog2(NREG);
    localparam int NB    = VLEN / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic init_done;
    int   checks = 0;
    int   errors = 0;

    logic [VLEN-1:0]  mmem [NREG];
    int               mptr [NBANK];
    logic [VLEN-1:0]  exp_rd [RPORT];
    logic [RPORT-1:0] exp_g;
`ifdef VRF_PARITY_EN
    bit               mbad [NREG][NB];
    logic [RPORT-1:0] exp_perr;
`endif

    always #5 clk = ~clk;

    vec_vrf_banked_if #(.NREG(NREG), .VLEN(VLEN), .WPORT(WPORT), .RPORT(RPORT)) bus ();

    vec_vrf_banked #(.NREG(NREG), .VLEN(VLEN), .NBANK(NBANK), .WPORT(WPORT), .RPORT(RPORT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .bus       (bus)
    );

    task automatic chk(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [VLEN-1:0] rand_vec();
        logic [VLEN-1:0] v;
        for (int w = 0; w < VLEN / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int raddr(input int i);
        return int'(bus.rd_addr[i*AW +: AW]);
    endfunction

    function automatic int waddr(input int p);
        return int'(bus.wr_addr[p*AW +: AW]);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            mmem[r] = '0;
`ifdef VRF_PARITY_EN
            for (int b = 0; b < NB; b++) mbad[r][b] = 1'b0;
`endif
        end
        for (int k = 0; k < NBANK; k++) mptr[k] = 0;
        for (int i = 0; i < RPORT; i++) exp_rd[i] = '0;
    endtask

    task automatic drive_idle();
        bus.wr_valid = '0;
        bus.wr_addr  = '0;
        bus.wr_be    = '0;
        bus.wr_data  = '0;
        bus.rd_valid = '0;
        bus.rd_addr  = '0;
`ifdef VRF_PARITY_EN
        bus.par_inj  = '0;
`endif
    endtask

    task automatic wr(input int p, input int a, input logic [VLEN-1:0] d, input logic [NB-1:0] be);
        bus.wr_valid[p]            = 1'b1;
        bus.wr_addr[p*AW +: AW]    = AW'(a);
        bus.wr_data[p*VLEN +: VLEN] = d;
        bus.wr_be[p*NB +: NB]      = be;
    endtask

    task automatic rd(input int i, input int a);
        bus.rd_valid[i]         = 1'b1;
        bus.rd_addr[i*AW +: AW] = AW'(a);
    endtask

    // One RUN cycle: predict grants/data from the model, advance the model, check responses.
    task automatic cyc();
        logic [VLEN-1:0] v;
        logic [NB-1:0]   fw;
        int              a, best, bd, d;
        @(negedge clk);
        exp_g = '0;
`ifdef VRF_PARITY_EN
        exp_perr = '0;
`endif
        for (int k = 0; k < NBANK; k++) begin
            best = -1;
            bd   = RPORT;
            for (int j = 0; j < RPORT; j++) begin
                if (bus.rd_valid[j] && (raddr(j) % NBANK) == k) begin
                    d = (j - mptr[k] + RPORT) % RPORT;
                    if (d < bd) begin
                        bd   = d;
                        best = j;
                    end
                end
            end
            if (best >= 0) begin
                exp_g[best] = 1'b1;
                mptr[k]     = (best + 1) % RPORT;
            end
        end
        chk("rd_ready", VLEN'(bus.rd_ready), VLEN'(exp_g));
        for (int i = 0; i < RPORT; i++) begin
            if (exp_g[i]) begin
                a  = raddr(i);
                v  = mmem[a];
                fw = '0;
                for (int p = 0; p < WPORT; p++) begin
                    for (int b = 0; b < NB; b++) begin
                        if (bus.wr_valid[p] && waddr(p) == a && bus.wr_be[p*NB + b]) begin
                            v[b*8 +: 8] = bus.wr_data[p*VLEN + b*8 +: 8];
                            fw[b]       = 1'b1;
                        end
                    end
                end
`ifdef VRF_PARITY_EN
                for (int b = 0; b < NB; b++) if (!fw[b] && mbad[a][b]) exp_perr[i] = 1'b1;
`endif
                exp_rd[i] = v;
            end
        end
        for (int p = 0; p < WPORT; p++) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.wr_valid[p] && bus.wr_be[p*NB + b]) begin
                    mmem[waddr(p)][b*8 +: 8] = bus.wr_data[p*VLEN + b*8 +: 8];
`ifdef VRF_PARITY_EN
                    mbad[waddr(p)][b] = bus.par_inj[p];
`endif
                end
            end
        end
        @(posedge clk);
        #1;
        chk("rd_rvalid", VLEN'(bus.rd_rvalid), VLEN'(exp_g));
        for (int i = 0; i < RPORT; i++)
            chk($sformatf("rd_rdata%0d", i), bus.rd_rdata[i*VLEN +: VLEN], exp_rd[i]);
`ifdef VRF_PARITY_EN
        chk("rd_perr", VLEN'(bus.rd_perr), VLEN'(exp_perr));
        bus.par_inj = '0;
`endif
        bus.rd_valid = bus.rd_valid & ~exp_g;
        bus.wr_valid = '0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (bus.rd_valid != '0 && n < budget) begin
            cyc();
            n++;
        end
        chk("drain", VLEN'(bus.rd_valid), '0);
    endtask

    // Entered at posedge+1 right after reset release; checks the NREG-cycle sweep.
    task automatic do_init();
        bus.wr_valid = '0;
        for (int i = 0; i < RPORT; i++) rd(i, i);
        for (int c = 0; c < NREG; c++) begin
            @(negedge clk);
            chk("init_done_low", VLEN'(init_done), '0);
            chk("init_rd_ready", VLEN'(bus.rd_ready), '0);
            chk("init_wr_ready", VLEN'(bus.wr_ready), '0);
            @(posedge clk);
            #1;
        end
        bus.rd_valid = '0;
        @(negedge clk);
        chk("init_done_high", VLEN'(init_done), VLEN'(1'b1));
        chk("run_wr_ready", VLEN'(bus.wr_ready), VLEN'({WPORT{1'b1}}));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VLEN-1:0] tmp;
        logic [NB-1:0]   be;
        drive_idle();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid", VLEN'(bus.rd_rvalid), '0);
        chk("rst_rdata0", bus.rd_rdata[0 +: VLEN], '0);
        chk("rst_init_done", VLEN'(init_done), '0);
        rst_n = 1'b1;
        do_init();

        // Four ports on bank 1: serialised in port order, pointer wraps back to 0.
        for (int i = 0; i < RPORT; i++) rd(i, 1 + 4 * i);
        for (int c = 0; c < RPORT; c++) begin
            cyc();
            chk("conflict_order", VLEN'(bus.rd_rvalid), VLEN'(1 << c));
        end
        for (int i = 0; i < RPORT; i++) rd(i, 1 + 4 * i);
        cyc();
        chk("bank1_ptr_wrap", VLEN'(bus.rd_rvalid), VLEN'(1));
        drain(20);

        for (int i = 0; i < RPORT; i++) rd(i, i);
        cyc();
        chk("parallel_grant", VLEN'(bus.rd_rvalid), VLEN'({RPORT{1'b1}}));

        for (int base = 0; base < NREG; base += RPORT) begin
            for (int i = 0; i < RPORT; i++) rd(i, base + i);
            drain(8);
        end

        wr(0, 5, {NB{8'hA5}}, '1);
        cyc();
        rd(0, 5);
        cyc();
        chk("a5_rvalid", VLEN'(bus.rd_rvalid[0]), VLEN'(1'b1));
        chk("a5_rdata", bus.rd_rdata[0 +: VLEN], {NB{8'hA5}});

        wr(0, 7, {NB{8'h11}}, '1);
        wr(1, 7, {NB{8'h22}}, {{(NB/2){1'b0}}, {(NB/2){1'b1}}});
        rd(2, 7);
        cyc();
        chk("fwd_rdata", bus.rd_rdata[2*VLEN +: VLEN], {{(NB/2){8'h11}}, {(NB/2){8'h22}}});
        rd(0, 7);
        cyc();
        chk("fwd_array", bus.rd_rdata[0 +: VLEN], {{(NB/2){8'h11}}, {(NB/2){8'h22}}});

`ifdef VRF_PARITY_EN
        wr(0, 2, rand_vec(), '1);
        bus.par_inj[0] = 1'b1;
        cyc();
        rd(0, 2);
        cyc();
        chk("perr_inject", VLEN'(bus.rd_perr[0]), VLEN'(1'b1));
`endif

        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < WPORT; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    tmp = rand_vec();
                    be  = ($urandom_range(0, 2) == 0) ? '1 : tmp[NB-1:0];
                    wr(p, $urandom_range(0, NREG - 1), rand_vec(), be);
`ifdef VRF_PARITY_EN
                    bus.par_inj[p] = ($urandom_range(0, 7) == 0);
`endif
                end
            end
            for (int i = 0; i < RPORT; i++) begin
                if (!bus.rd_valid[i]) begin
                    if ($urandom_range(0, 9) < 6)
                        rd(i, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1));
                end else if ($urandom_range(0, 9) == 0) begin
                    bus.rd_valid[i] = 1'b0;
                end
            end
            cyc();
        end
        drain(20);

        // Reset in the middle of RUN wipes outputs and storage.
        wr(0, 3, {NB{8'hFF}}, '1);
        cyc();
        rd(0, 3);
        cyc();
        chk("v3_written", bus.rd_rdata[0 +: VLEN], {NB{8'hFF}});
        rd(1, 6);
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_ready", VLEN'(bus.rd_ready), '0);
        chk("midrst_rvalid", VLEN'(bus.rd_rvalid), '0);
        chk("midrst_rdata0", bus.rd_rdata[0 +: VLEN], '0);
        chk("midrst_init_done", VLEN'(init_done), '0);
        chk("midrst_wr_ready", VLEN'(bus.wr_ready), '0);
        drive_idle();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_init();
        rd(1, 3);
        cyc();
        chk("v3_cleared", bus.rd_rdata[1*VLEN +: VLEN], '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
